sprite_blitter: RTL and testbench
=================================

# sprite_blitter

Parametrised, pipelined sprite renderer for the VGA pixel path. Compares the current scan coordinate against a runtime-movable sprite rectangle, generates the address into an external synchronous sprite ROM holding `FRAMES` images, and returns a registered colour plus a `hit` flag for the display mux. Position and frame changes are double-buffered and take effect only at frame start, so they never tear.

## Interface
Parameters:
- `SPR_W`, 33: sprite width in source pixels.
- `SPR_H`, 17: sprite height in source pixels.
- `FRAMES`, 1: images stored back-to-back in ROM. Frame f starts at f*SPR_W*SPR_H.
- `SCALE`, 0: integer upscale shift. Each source pixel covers 2^SCALE x 2^SCALE screen pixels.
- `ADDR_W`, 10: ROM address width. Must satisfy FRAMES*SPR_W*SPR_H <= 2^ADDR_W.
- `POS_X0`, 0: reset X position.
- `POS_Y0`, 0: reset Y position.
- `KEY`, 8'hE3: transparent colour key.

Ports:
- `clk`  in  1  pixel clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `en`  in  1  sprite enable; when low, every pixel is treated as outside the sprite.
- `x`, `y`  in  10 each  current scan coordinate.
- `frame_start`  in  1  one-cycle pulse at the start of each frame (vsync edge).
- `pos_we`  in  1  loads the shadow position.
- `pos_x_in`, `pos_y_in`  in  10 each  new position.
- `frame_sel`  in  clog2(FRAMES) (min 1)  requested image index, sampled at `frame_start`.
- `rom_addr`  out  ADDR_W  registered address to the sprite ROM.
- `rom_data`  in  8  ROM output, valid one cycle after `rom_addr`.
- `rgb`  out  8  pixel colour (RRRGGGBB).
- `hit`  out  1  high when `rgb` is an opaque sprite pixel.

## Operation
- Registers:
  - shadow_x/shadow_y: loaded on `pos_we`.
  - act_x/act_y/act_frame: loaded from the shadows and `frame_sel` when `frame_start`=1.
  - If `pos_we` and `frame_start` arrive in the same cycle, act_* take the new `pos_*_in` values directly (the write wins).
- Stage 1 (S1), registered:
  - dx = x - act_x and dy = y - act_y, computed in 11 bits signed.
  - inside = en && dx>=0 && dx < SPR_W<<SCALE && dy>=0 && dy < SPR_H<<SCALE.
  - Sprites partly past x/y = 1023 clip naturally; no wrap-around.
- Stage 2 (S2):
  - rom_addr = act_frame*SPR_W*SPR_H + (dy>>SCALE)*SPR_W + (dx>>SCALE). Multiplies are by constants.
  - When not inside, rom_addr = 0.
  - `inside` is delayed alongside.
- Stage 3 (S3):
  - If inside_d and rom_data != KEY: rgb=rom_data, hit=1.
  - Otherwise: rgb=8'h00, hit=0.
- act_* only change at `frame_start`. A mid-line `pos_we` never moves the sprite within the current frame.

## Timing
- Latency from x/y to rgb/hit is 3 clocks, fully pipelined at one pixel per clock with no stalls.
- On reset (`rst_n` low at a clk edge), all of the following apply on the next edge:
  - rom_addr=0, rgb=0, hit=0.
  - shadow_* and act_* = POS_X0/POS_Y0.
  - act_frame=0.
  - Pipeline valid/inside bits = 0.
- Reset mid-line: outputs are 0 from the next edge. Rendering resumes with the first pixel presented after release, 3 clocks later.
- `en` falling or rising affects the pixel sampled in that cycle. Pixels already in flight complete normally.
- frame_sel >= FRAMES is clamped to FRAMES-1 when latched.

## Configuration
- `SPRITE_TRANSP_EN` defined:
  - Pixels equal to `KEY` are transparent: hit=0, rgb=0.
- Not defined:
  - The key comparison is removed.
  - Every inside pixel gives hit=1 and rgb=rom_data.
  - `KEY` is ignored.

## Test plan
- Reset defaults: hold rst_n=0 for 2 clocks -> rgb=0, hit=0, rom_addr=0. First frame renders at (POS_X0,POS_Y0).
- Addressing, SCALE=0, pos (100,50), frame 0: scan x=100..132, y=50 -> rom_addr 0..32 two clocks after each x, and hit rises 3 clocks after x=100. Pixel (132,66) -> addr 560. Pixel (133,50) -> hit=0.
- Scaling, SCALE=1: pixels (100,50),(101,50),(100,51) all give addr 0. Pixel (102,50) gives addr 1. Coverage is 66x34.
- Double-buffer: pos_we mid-frame with (200,100) -> sprite still at (100,50) until frame_start, then at (200,100). Simultaneous pos_we+frame_start applies the new value immediately.
- Frames and clipping, FRAMES=2: frame_sel=1 latched -> sprite origin addr = 561. Pos (1010,0) -> hit only for x 1010..1023, no wrap to x=0.
- Transparency (macro on): ROM word = 8'hE3 -> hit=0, rgb=0. With macro off, same pixel -> hit=1, rgb=8'hE3.

Source files
------------

// File: rtl/sprite_blitter.sv
// sprite_blitter: pipelined sprite renderer for the VGA pixel path.
// Stage 1 tests the scan coordinate against the active sprite rectangle.
// Stage 2 registers the sprite ROM address. Stage 3 combines the registered
// ROM word with the delayed inside flag.
// Position and frame writes are double-buffered and take effect at frame_start.
// Optional macro SPRITE_TRANSP_EN: pixels equal to KEY become transparent.
module sprite_blitter #(
   parameter int          SPR_W  = 33,
   parameter int          SPR_H  = 17,
   parameter int          FRAMES = 1,
   parameter int          SCALE  = 0,
   parameter int          ADDR_W = 10,
   parameter logic [9:0]  POS_X0 = 10'd0,
   parameter logic [9:0]  POS_Y0 = 10'd0,
   parameter logic [7:0]  KEY    = 8'hE3,
   localparam int         FS_W   = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic [9:0]        x,
   input  logic [9:0]        y,
   input  logic              frame_start,
   input  logic              pos_we,
   input  logic [9:0]        pos_x_in,
   input  logic [9:0]        pos_y_in,
   input  logic [FS_W-1:0]   frame_sel,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [7:0]        rom_data,
   output logic [7:0]        rgb,
   output logic              hit
);

   localparam logic [10:0]       X_LIM      = 11'(SPR_W << SCALE);
   localparam logic [10:0]       Y_LIM      = 11'(SPR_H << SCALE);
   localparam logic [FS_W-1:0]   LAST_FRAME = FS_W'(FRAMES - 1);
   localparam logic [ADDR_W-1:0] FRAME_SZ   = ADDR_W'(SPR_W * SPR_H);
   localparam logic [ADDR_W-1:0] ROW_SZ     = ADDR_W'(SPR_W);

   // Position / frame registers
   logic [9:0]        shadow_x_q, shadow_x_d;
   logic [9:0]        shadow_y_q, shadow_y_d;
   logic [9:0]        act_x_q, act_x_d;
   logic [9:0]        act_y_q, act_y_d;
   logic [FS_W-1:0]   act_frame_q, act_frame_d;

   // Stage 1: offsets into the sprite, frame carried with the pixel
   logic [9:0]        dx1_q, dx1_d;
   logic [9:0]        dy1_q, dy1_d;
   logic [FS_W-1:0]   frm1_q, frm1_d;
   logic              in1_q, in1_d;

   // Stage 2: ROM address, Stage 3: inside flag aligned with rom_data
   logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
   logic              in2_q, in2_d;
   logic              in3_q, in3_d;

   logic [10:0]       dx, dy;
   logic [FS_W-1:0]   sel_clamped;
   logic              opaque;

   // Shadow loads on pos_we; active copy refreshes only at frame_start, a
   // simultaneous write bypassing the shadow
   always_comb begin
      shadow_x_d  = shadow_x_q;
      shadow_y_d  = shadow_y_q;
      act_x_d     = act_x_q;
      act_y_d     = act_y_q;
      act_frame_d = act_frame_q;
      sel_clamped = (frame_sel > LAST_FRAME) ? LAST_FRAME : frame_sel;
      if (pos_we) begin
         shadow_x_d = pos_x_in;
         shadow_y_d = pos_y_in;
      end
      if (frame_start) begin
         act_x_d     = pos_we ? pos_x_in : shadow_x_q;
         act_y_d     = pos_we ? pos_y_in : shadow_y_q;
         act_frame_d = sel_clamped;
      end
   end

   // Pixel pipeline: rectangle test, then address build from constant multiplies
   always_comb begin
      dx     = {1'b0, x} - {1'b0, act_x_q};
      dy     = {1'b0, y} - {1'b0, act_y_q};
      dx1_d  = dx[9:0];
      dy1_d  = dy[9:0];
      frm1_d = act_frame_q;
      in1_d  = en && !dx[10] && (dx < X_LIM) && !dy[10] && (dy < Y_LIM);
      rom_addr_d = '0;
      if (in1_q) begin
         rom_addr_d = ADDR_W'(frm1_q) * FRAME_SZ
                    + ADDR_W'(dy1_q >> SCALE) * ROW_SZ
                    + ADDR_W'(dx1_q >> SCALE);
      end
      in2_d = in1_q;
      in3_d = in2_q;
   end

`ifdef SPRITE_TRANSP_EN
   // Colour-keyed output: the key colour is see-through
   always_comb begin
      opaque = in3_q && (rom_data != KEY);
   end
`else
   // Every pixel inside the rectangle is drawn; KEY has no effect here
   logic key_unused;
   assign key_unused = ^KEY;
   always_comb begin
      opaque = in3_q;
   end
`endif

   assign hit      = opaque;
   assign rgb      = opaque ? rom_data : 8'h00;
   assign rom_addr = rom_addr_q;

   // All state registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         shadow_x_q  <= POS_X0;
         shadow_y_q  <= POS_Y0;
         act_x_q     <= POS_X0;
         act_y_q     <= POS_Y0;
         act_frame_q <= '0;
         dx1_q       <= '0;
         dy1_q       <= '0;
         frm1_q      <= '0;
         in1_q       <= 1'b0;
         rom_addr_q  <= '0;
         in2_q       <= 1'b0;
         in3_q       <= 1'b0;
      end else begin
         shadow_x_q  <= shadow_x_d;
         shadow_y_q  <= shadow_y_d;
         act_x_q     <= act_x_d;
         act_y_q     <= act_y_d;
         act_frame_q <= act_frame_d;
         dx1_q       <= dx1_d;
         dy1_q       <= dy1_d;
         frm1_q      <= frm1_d;
         in1_q       <= in1_d;
         rom_addr_q  <= rom_addr_d;
         in2_q       <= in2_d;
         in3_q       <= in3_d;
      end
   end

endmodule

// File: tb/tb_sprite_blitter.sv
// tb_sprite_blitter: two instances share the scan inputs. dut_a is unscaled with
// two frames; dut_b uses SCALE=1 and a single frame, so frame_sel=1 is clamped.
module tb_sprite_blitter;

   localparam bit          TRANSP = `ifdef SPRITE_TRANSP_EN 1'b1 `else 1'b0 `endif ;
   localparam logic [7:0]  KEY    = 8'hE3;
   localparam int          PX0    = 5;
   localparam int          PY0    = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b1;
   logic [9:0]  x = '0, y = '0;
   logic        frame_start = 1'b0, pos_we = 1'b0;
   logic [9:0]  pos_x_in = '0, pos_y_in = '0;
   logic [0:0]  frame_sel = '0;
   logic [10:0] rom_addr_a;
   logic [9:0]  rom_addr_b;
   logic [7:0]  rom_data_a, rom_data_b, rgb_a, rgb_b;
   logic        hit_a, hit_b;

   logic [7:0]  rom_a [0:2047];
   logic [7:0]  rom_b [0:1023];

   int n_vec = 0;
   int n_mis = 0;

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   sprite_blitter #(.SPR_W(33), .SPR_H(17), .FRAMES(2), .SCALE(0), .ADDR_W(11),
                    .POS_X0(10'd5), .POS_Y0(10'd3), .KEY(8'hE3)) dut_a (
      .clk(clk), .rst_n(rst_n), .en(en), .x(x), .y(y), .frame_start(frame_start),
      .pos_we(pos_we), .pos_x_in(pos_x_in), .pos_y_in(pos_y_in), .frame_sel(frame_sel),
      .rom_addr(rom_addr_a), .rom_data(rom_data_a), .rgb(rgb_a), .hit(hit_a));

   sprite_blitter #(.SPR_W(33), .SPR_H(17), .FRAMES(1), .SCALE(1), .ADDR_W(10),
                    .POS_X0(10'd5), .POS_Y0(10'd3), .KEY(8'hE3)) dut_b (
      .clk(clk), .rst_n(rst_n), .en(en), .x(x), .y(y), .frame_start(frame_start),
      .pos_we(pos_we), .pos_x_in(pos_x_in), .pos_y_in(pos_y_in), .frame_sel(frame_sel),
      .rom_addr(rom_addr_b), .rom_data(rom_data_b), .rgb(rgb_b), .hit(hit_b));

   // synchronous sprite ROMs
   always @(posedge clk) begin
      rom_data_a <= rom_a[rom_addr_a];
      rom_data_b <= rom_b[rom_addr_b];
   end

   // ---------------- reference model ----------------
   function automatic bit opaque(input logic [7:0] d);
      return TRANSP ? (d != KEY) : 1'b1;
   endfunction

   // ROM index of a screen pixel for a sprite at (ax,ay), or -1 if not covered
   function automatic int pix(input int px, input int py, input bit e,
                              input int ax, input int ay, input int af, input int sc);
      if (e && px >= ax && px < ax + (33 << sc) && py >= ay && py < ay + (17 << sc))
         return af * 561 + ((py - ay) >> sc) * 33 + ((px - ax) >> sc);
      return -1;
   endfunction

   int m_sx = PX0, m_sy = PY0, m_ax = PX0, m_ay = PY0, m_fa = 0;
   int cyc = 0;
   int h_pa [8];
   int h_pb [8];
   bit h_rst [8];

   // record each sampled pixel's expected ROM index, then advance the registers
   always @(posedge clk) begin
      h_rst[cyc & 7] = rst_n;
      h_pa[cyc & 7]  = pix(int'(x), int'(y), en, m_ax, m_ay, m_fa, 0);
      h_pb[cyc & 7]  = pix(int'(x), int'(y), en, m_ax, m_ay, 0, 1);
      if (!rst_n) begin
         m_sx = PX0; m_sy = PY0; m_ax = PX0; m_ay = PY0; m_fa = 0;
      end else begin
         if (frame_start) begin
            m_ax = pos_we ? int'(pos_x_in) : m_sx;
            m_ay = pos_we ? int'(pos_y_in) : m_sy;
            m_fa = (int'(frame_sel) > 1) ? 1 : int'(frame_sel);
         end
         if (pos_we) begin
            m_sx = int'(pos_x_in);
            m_sy = int'(pos_y_in);
         end
      end
      cyc = cyc + 1;
   end

   // ---------------- scoreboard ----------------
   task automatic chk(input string nm, input int act, input int exp);
      n_vec = n_vec + 1;
      if (act != exp) begin
         n_mis = n_mis + 1;
         $display("FAIL %s @%0t: got %0d, expected %0d", nm, $time, act, exp);
      end
   endtask

   int  c2, c3, ea, eb, ia, ib;
   bit  ok2, ok3;

   // every cycle: address two clocks and colour three clocks after the pixel
   always @(negedge clk) begin
      if (cyc >= 1) begin
         c2  = cyc - 2;
         ok2 = (c2 >= 0) && h_rst[c2 & 7] && h_rst[(c2 + 1) & 7];
         ea  = (ok2 && h_pa[c2 & 7] >= 0) ? h_pa[c2 & 7] : 0;
         eb  = (ok2 && h_pb[c2 & 7] >= 0) ? h_pb[c2 & 7] : 0;
         chk("stream_addr_a", int'(rom_addr_a), ea);
         chk("stream_addr_b", int'(rom_addr_b), eb);
         c3  = cyc - 3;
         ok3 = (c3 >= 0) && h_rst[c3 & 7] && h_rst[(c3 + 1) & 7] && h_rst[(c3 + 2) & 7];
         ia  = ok3 ? h_pa[c3 & 7] : -1;
         ib  = ok3 ? h_pb[c3 & 7] : -1;
         chk("stream_hit_a", int'(hit_a), (ia >= 0) ? int'(opaque(rom_a[ia])) : 0);
         chk("stream_rgb_a", int'(rgb_a), (ia >= 0 && opaque(rom_a[ia])) ? int'(rom_a[ia]) : 0);
         chk("stream_hit_b", int'(hit_b), (ib >= 0) ? int'(opaque(rom_b[ib])) : 0);
         chk("stream_rgb_b", int'(rgb_b), (ib >= 0 && opaque(rom_b[ib])) ? int'(rom_b[ib]) : 0);
      end
   end

   // compare settled outputs against expected ROM indices (-1 = no sprite)
   task automatic chk_out(input string nm, input int pa, input int pb);
      chk({nm, "_addr_a"}, int'(rom_addr_a), (pa >= 0) ? pa : 0);
      chk({nm, "_addr_b"}, int'(rom_addr_b), (pb >= 0) ? pb : 0);
      chk({nm, "_hit_a"}, int'(hit_a), (pa >= 0) ? int'(opaque(rom_a[pa])) : 0);
      chk({nm, "_rgb_a"}, int'(rgb_a), (pa >= 0 && opaque(rom_a[pa])) ? int'(rom_a[pa]) : 0);
      chk({nm, "_hit_b"}, int'(hit_b), (pb >= 0) ? int'(opaque(rom_b[pb])) : 0);
      chk({nm, "_rgb_b"}, int'(rgb_b), (pb >= 0 && opaque(rom_b[pb])) ? int'(rom_b[pb]) : 0);
   endtask

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic px(input int xv, input int yv);
      x = 10'(xv);
      y = 10'(yv);
      step();
   endtask

   task automatic hold(input int xv, input int yv);
      x = 10'(xv);
      y = 10'(yv);
      repeat (3) step();
   endtask

   task automatic scan(input int yv, input int x0, input int x1);
      for (int i = x0; i <= x1; i++) px(i, yv);
   endtask

   task automatic wpos(input int xv, input int yv, input bit fs, input int sel);
      pos_we      = 1'b1;
      pos_x_in    = 10'(xv);
      pos_y_in    = 10'(yv);
      frame_start = fs;
      frame_sel   = 1'(sel);
      step();
      pos_we      = 1'b0;
      frame_start = 1'b0;
   endtask

   task automatic fstart(input int sel);
      frame_start = 1'b1;
      frame_sel   = 1'(sel);
      step();
      frame_start = 1'b0;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      int x;
      int y;
      int pa;
      int pb;
   } vec_t;

   vec_t tbl [13];

   int cur_x, cur_y, rx, ry;

   initial begin
      for (int i = 0; i < 2048; i++) rom_a[i] = 8'($urandom);
      for (int i = 0; i < 1024; i++) rom_b[i] = 8'($urandom);
      rom_a[0] = 8'h11; rom_b[0] = 8'h22;
      rom_a[1] = 8'h12; rom_a[13] = 8'h5A;
      rom_a[5] = KEY;   rom_b[2] = KEY;

      // sprite at (100,50), frame 0
      tbl[0]  = '{100, 50,   0,   0};
      tbl[1]  = '{101, 50,   1,   0};
      tbl[2]  = '{100, 51,  33,   0};
      tbl[3]  = '{102, 50,   2,   1};
      tbl[4]  = '{132, 50,  32,  16};
      tbl[5]  = '{132, 66, 560, 280};
      tbl[6]  = '{133, 50,  -1,  16};
      tbl[7]  = '{116, 60, 346, 173};
      tbl[8]  = '{ 99, 50,  -1,  -1};
      tbl[9]  = '{165, 83,  -1, 560};
      tbl[10] = '{166, 50,  -1,  -1};
      tbl[11] = '{100, 84,  -1,  -1};
      tbl[12] = '{100, 83,  -1, 528};

      // reset defaults
      repeat (2) step();
      chk_out("reset", -1, -1);
      rst_n = 1'b1;

      // first frame at the reset position
      scan(PY0, 0, 45);
      hold(5, 3);
      chk_out("reset_pos", 0, 0);
      hold(6, 3);
      chk_out("reset_pos_next", 1, 0);

      // addressing and scaling table
      wpos(100, 50, 1'b0, 0);
      fstart(0);
      for (int i = 0; i < 13; i++) begin
         hold(tbl[i].x, tbl[i].y);
         chk_out($sformatf("tbl%0d", i), tbl[i].pa, tbl[i].pb);
      end
      scan(50, 95, 140);

      // double buffering: a mid-frame write waits for frame_start
      wpos(200, 100, 1'b0, 0);
      hold(100, 50);
      chk_out("dbuf_old", 0, 0);
      hold(200, 100);
      chk_out("dbuf_not_yet", -1, -1);
      fstart(0);
      hold(200, 100);
      chk_out("dbuf_new", 0, 0);
      hold(100, 50);
      chk_out("dbuf_old_gone", -1, -1);

      // write coinciding with frame_start wins
      wpos(300, 200, 1'b1, 0);
      hold(300, 200);
      chk_out("same_cycle", 0, 0);

      // second frame; dut_b clamps frame_sel to 0
      wpos(100, 50, 1'b1, 1);
      hold(100, 50);
      chk_out("frame1_origin", 561, 0);
      hold(132, 66);
      chk_out("frame1_last", 1121, 280);

      // right-edge clipping
      wpos(1010, 0, 1'b1, 0);
      scan(0, 1000, 1023);
      scan(0, 0, 20);
      hold(1023, 0);
      chk_out("clip_edge", 13, 6);
      hold(0, 0);
      chk_out("clip_nowrap", -1, -1);

      // colour key word
      wpos(100, 50, 1'b1, 0);
      hold(105, 50);
      chk_out("key_pixel", 5, 2);

      // enable low then high around the sprite
      en = 1'b0;
      hold(101, 50);
      chk_out("en_low", -1, -1);
      en = 1'b1;
      hold(101, 50);
      chk_out("en_high", 1, 0);

      // reset in the middle of a line
      for (int i = 95; i <= 140; i++) begin
         rst_n = (i != 110);
         px(i, 50);
      end
      rst_n = 1'b1;
      hold(100, 50);
      chk_out("post_reset_old", -1, -1);
      hold(5, 3);
      chk_out("post_reset_pos", 0, 0);

      // randomized stream
      cur_x = 100; cur_y = 50;
      for (int n = 0; n < 3000; n++) begin
         rst_n       = ($urandom_range(0, 699) != 0);
         en          = ($urandom_range(0, 9) != 0);
         frame_start = ($urandom_range(0, 19) == 0);
         frame_sel   = 1'($urandom_range(0, 1));
         pos_we      = ($urandom_range(0, 39) == 0);
         if (pos_we) begin
            cur_x = ($urandom_range(0, 3) == 0) ? int'($urandom_range(960, 1023))
                                                : int'($urandom_range(0, 1023));
            cur_y = ($urandom_range(0, 3) == 0) ? int'($urandom_range(990, 1023))
                                                : int'($urandom_range(0, 1023));
            pos_x_in = 10'(cur_x);
            pos_y_in = 10'(cur_y);
         end
         rx = cur_x + int'($urandom_range(0, 90)) - 10;
         ry = cur_y + int'($urandom_range(0, 45)) - 5;
         if (rx < 0) rx = 0;
         if (rx > 1023) rx = 1023;
         if (ry < 0) ry = 0;
         if (ry > 1023) ry = 1023;
         px(rx, ry);
      end
      rst_n = 1'b1; en = 1'b1; pos_we = 1'b0; frame_start = 1'b0;
      repeat (4) step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
